// File: rtl/ram_access_seq.sv
// rtl/ram_access_seq.sv - register-array RAM behind a four-state latch/access/acknowledge request sequencer
module ram_access_seq #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              ack,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LATCH  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic              we_l;
    logic [DATA_W-1:0] mem [DEPTH];

    // Request fields are frozen into MAR/MDR/we_l at capture; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mar   <= '0;
            mdr   <= '0;
            we_l  <= 1'b0;
            rdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        mar   <= addr;
                        mdr   <= wdata;
                        we_l  <= we;
                        state <= LATCH;
                    end
                end
                LATCH: state <= ACCESS;
                ACCESS: begin
                    if (we_l) begin
                        mem[mar] <= mdr;
                    end else begin
                        rdata <= mem[mar];
                    end
                    state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == LATCH) || (state == ACCESS);
    assign ack  = (state == DONE);
endmodule

// File: tb/tb_ram_access_seq.sv
// tb/tb_ram_access_seq.sv - directed and randomized bench for ram_access_seq against an edge-count reference model
module tb_ram_access_seq;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          busy;
    logic          ack;
    logic [DW-1:0] rdata;

    always #5 clk = ~clk;

    ram_access_seq #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .busy  (busy),
        .ack   (ack),
        .rdata (rdata)
    );

    int tests = 0;
    int fails = 0;

    // Model: a request captured at edge C is busy after edges C and C+1, acks after C+2,
    // commits at edge C+2, and the next capture is possible from edge C+4.
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_rdata = '0;
    int            edge_no = 0;
    int            cap_e = -100;
    logic          c_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_no, act, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic q, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        int since;
        reset = r;
        req   = q;
        we    = w;
        addr  = a;
        wdata = d;
        edge_no++;
        since = edge_no - cap_e;
        if (r) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_rdata = '0;
            cap_e   = edge_no - 4;
        end else if (since >= 4 && q) begin
            cap_e   = edge_no;
            c_we    = w;
            c_addr  = a;
            c_wdata = d;
        end else if (since == 2) begin
            if (c_we) m_mem[c_addr] = c_wdata;
            else m_rdata = m_mem[c_addr];
        end
        @(negedge clk);
        since = edge_no - cap_e;
        chk("busy", 32'(busy), 32'(since == 0 || since == 1));
        chk("ack", 32'(ack), 32'(since == 2));
        chk("rdata", 32'(rdata), 32'(m_rdata));
    endtask

    task automatic txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output logic [DW-1:0] rd);
        cycle(1'b0, 1'b1, w, a, d);
        cycle(1'b0, 1'b0, 1'b0, '0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0, '0);
        rd = rdata;
        cycle(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [DW-1:0] rd;
        int            acks;
        int            ack_at [$];

        // Reset held two cycles with a pending request that must not be captured
        cycle(1'b1, 1'b1, 1'b0, 4'd5, 8'h00);
        cycle(1'b1, 1'b1, 1'b0, 4'd5, 8'h00);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'h00);
        cycle(1'b0, 1'b0, 1'b0, 4'd5, 8'h00);
        chk("post_reset_idle", 32'(busy), 32'd0);

        // Write timing
        cycle(1'b0, 1'b1, 1'b1, 4'd3, 8'hA5);
        chk("wr_busy_n", 32'(busy), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        chk("wr_busy_n1", 32'(busy), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        chk("wr_ack_n2", 32'(ack), 32'd1);
        chk("wr_ack_busy", 32'(busy), 32'd0);
        chk("wr_ack_rdata", 32'(rdata), 32'h00);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        chk("wr_ack_n3", 32'(ack), 32'd0);

        txn(1'b0, 4'd3, 8'h00, rd);
        chk("rd_after_wr", 32'(rd), 32'hA5);

        // Capture isolation: address and data changed after the capture edge
        cycle(1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 4'd7, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 4'd7, 8'h00);
        chk("iso_addr", 32'(rdata), 32'hA5);
        cycle(1'b0, 1'b0, 1'b0, 4'd7, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 4'd4, 8'h3C);
        cycle(1'b0, 1'b1, 1'b1, 4'd4, 8'hFF);
        cycle(1'b0, 1'b1, 1'b1, 4'd4, 8'hFF);
        cycle(1'b0, 1'b0, 1'b1, 4'd4, 8'hFF);
        txn(1'b0, 4'd4, 8'h00, rd);
        chk("iso_wdata", 32'(rd), 32'h3C);

        // Continuous request: captures at 0, 4, 8
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b1, 1'b1, AW'(i / 4), DW'(8'h11 * (i / 4 + 1)));
            if (ack) begin
                acks++;
                ack_at.push_back(i);
            end
        end
        chk("cont_acks", 32'(acks), 32'd3);
        if (ack_at.size() == 3) begin
            chk("cont_spacing1", 32'(ack_at[1] - ack_at[0]), 32'd4);
            chk("cont_spacing2", 32'(ack_at[2] - ack_at[1]), 32'd4);
        end
        cycle(1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            txn(1'b0, AW'(i), 8'h00, rd);
            chk("cont_readback", 32'(rd), 32'(8'h11 * (i + 1)));
        end

        // Boundary addresses
        txn(1'b1, 4'd15, 8'h80, rd);
        txn(1'b1, 4'd0, 8'h01, rd);
        txn(1'b0, 4'd15, 8'h00, rd);
        chk("bound_15", 32'(rd), 32'h80);
        txn(1'b0, 4'd0, 8'h00, rd);
        chk("bound_0", 32'(rd), 32'h01);
        txn(1'b0, 4'd9, 8'h00, rd);
        chk("bound_9", 32'(rd), 32'h00);

        // Reset on the access edge of a write; addr 2 previously held 0x33
        cycle(1'b0, 1'b1, 1'b1, 4'd2, 8'h5A);
        cycle(1'b0, 1'b0, 1'b0, 4'd2, 8'h5A);
        cycle(1'b1, 1'b0, 1'b0, 4'd2, 8'h5A);
        chk("abort_ack", 32'(ack), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 4'd2, 8'h00);
        chk("abort_recapture", 32'(busy), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        chk("abort_ack_read", 32'(ack), 32'd1);
        chk("abort_rdata", 32'(rdata), 32'h00);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  AW'($urandom), DW'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ram_access_seq.md
Name: ram_access_seq

Overview:
- Synchronous memory stage that consumes the flip-flop storage primitive: a 2^ADDR_W x DATA_W register-array RAM with a request sequencer in front of it.
- Internally it holds a memory address register (MAR), a memory data register (MDR) and a latched write-enable; a Moore FSM steps each request through a fixed latch/access/acknowledge sequence.
- Sits between the CPU control sequencer (requester) and the storage array. It is the memory port the CPU bus controller drives.

Parameters:
- ADDR_W, 4, address width; depth = 2^ADDR_W words.
- DATA_W, 8, word width in bits.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  request strobe; sampled only in IDLE.
- we  input  1  1 = write, 0 = read; captured with req.
- addr  input  ADDR_W  word address; captured with req.
- wdata  input  DATA_W  write data; captured with req.
- busy  output  1  high while a request is in flight (LATCH, ACCESS).
- ack  output  1  one-cycle completion pulse (DONE).
- rdata  output  DATA_W  registered read data; valid from ack onward.

Behaviour:
- Reset (reset=1 at a rising edge) applies to everything:
  - state=IDLE; MAR=0, MDR=0, latched we=0.
  - rdata=0, every memory word=0; busy=0, ack=0.
  - Reset has priority over every other action at the same edge.
- FSM states: IDLE, LATCH, ACCESS, DONE. busy and ack are decoded from state (Moore, no combinational path from inputs).
- IDLE:
  - req=1 at edge N: MAR<=addr, MDR<=wdata, we_l<=we, go to LATCH.
  - req=0: stay in IDLE.
- LATCH: go to ACCESS unconditionally (address-settle cycle); busy=1.
- ACCESS: busy=1. At edge N+2, go to DONE and:
  - if we_l=1: mem[MAR]<=MDR, rdata unchanged.
  - if we_l=0: rdata<=mem[MAR], memory unchanged.
- DONE: ack=1, busy=0. Go to IDLE unconditionally at edge N+3.
- Latency: req sampled at edge N; ack high between edges N+2 and N+3. rdata is valid from edge N+2 and holds until the next read completes or reset.
- Throughput: one transaction per 4 cycles. With req held high continuously, a new capture occurs at edges N, N+4, N+8, ...
- req is ignored in LATCH/ACCESS/DONE. No queuing; a request presented outside IDLE is dropped. The requester must wait for ack and then re-present in IDLE.
- addr/wdata/we changes after the capture edge have no effect on the in-flight transaction.
- Read-after-write to the same address returns the newly written value; no bypass is needed because the write commits before the next capture.
- Address space is fully decoded: every value 0..2^ADDR_W-1 is valid and there is no wrap or out-of-range case.
- Reset mid-transaction:
  - The transaction is aborted with no ack.
  - If reset coincides with the ACCESS edge, no write and no rdata update occur, and memory is cleared anyway.
- X-free: all registers are reset, and outputs are never X after the first reset edge.

Test Plan:
- Reset check: hold reset 2 cycles with req=1, addr=5 -> busy=0, ack=0, rdata=0x00, state IDLE; no capture while reset is high.
- Write/read timing: write 0xA5 to addr 3 (req at edge N) -> busy=1 for N..N+2, ack=1 exactly during N+2..N+3. Then read addr 3 -> rdata=0xA5 at its ack; rdata still 0x00 during the write's ack.
- Capture isolation: read addr 3 with addr changed to 7 one cycle after the req edge -> rdata=0xA5, not mem[7]=0x00. Write 0x3C with wdata changed to 0xFF mid-flight -> mem holds 0x3C.
- Continuous req: hold req=1 for 12 cycles, writing addr 0,1,2 with data 0x11,0x22,0x33 -> exactly 3 acks, 4 cycles apart; readback gives 0x11,0x22,0x33.
- Boundary addresses: write 0x80 to addr 15 and 0x01 to addr 0 -> reads return 0x80 and 0x01; an unwritten addr 9 reads 0x00.
- Reset during ACCESS of a write of 0x5A to addr 2 -> no ack; a subsequent read of addr 2 returns 0x00; the FSM accepts a new req on the first edge after reset deasserts.
